mc_maindec: RTL and testbench
=============================

Name: mc_maindec

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM that sequences each instruction over several cycles: fetch, decode, execute, memory, writeback.
- Sits in the multicycle MIPS controller beside aludec; drives datapath mux selects and write enables.
- Generalised with a parametrised memory latency (memory states stretch over MEM_LAT cycles) and an illegal-opcode trap.

Parameters:
- MEM_LAT, 1, number of cycles each memory-access state (FETCH, MEMRD, MEMWR) is held; legal range 1..15.
- OP_W, 6, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- op  in  OP_W  opcode field from instruction register, sampled in DECODE.
- memtoreg  out  1  register write data = memory data register.
- regdst  out  1  destination = rd (1) / rt (0).
- iord  out  1  memory address = ALUOut (1) / PC (0).
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alusrcb  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alusrca  out  1  ALU A = reg A (1) / PC (0).
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write (ANDed with zero in datapath).
- regwrite  out  1  register file write.
- link  out  1  jal: write PC into register 31.
- alushiftop  out  2  to aludec: 00 add, 01 sub, 10 funct-decoded.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, JALEX 12, BNEEX 13 (only with the optional feature), TRAP 14.
- Reset (asynchronous): state = FETCH, wait counter = 0.
- All outputs are a pure function of state and wait counter (Moore). Any output not listed for a state is 0.
- Because FETCH is entered on reset, the outputs during reset are the FETCH values: alusrcb = 01, all else 0; irwrite and pcwrite are 0 unless MEM_LAT = 1.
- Output values per state:
  - FETCH: alusrcb = 01. On the last wait cycle only, irwrite = 1 and pcwrite = 1.
  - DECODE: alusrcb = 11.
  - MEMADR: alusrca = 1, alusrcb = 10.
  - MEMRD: iord = 1.
  - MEMWB: memtoreg = 1, regwrite = 1.
  - MEMWR: iord = 1. On the last wait cycle only, memwrite = 1.
  - RTYPEEX: alusrca = 1, alushiftop = 10.
  - RTYPEWB: regdst = 1, regwrite = 1.
  - BEQEX: alusrca = 1, alushiftop = 01, pcsrc = 01, branch = 1.
  - ADDIEX: alusrca = 1, alusrcb = 10.
  - ADDIWB: regwrite = 1.
  - JEX: pcsrc = 10, pcwrite = 1.
  - JALEX: pcsrc = 10, pcwrite = 1, regwrite = 1, link = 1.
  - TRAP: illegal = 1.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Counts 0..MEM_LAT-1 while in one of these states.
  - The state advances only when the counter equals MEM_LAT-1; the counter then clears to 0.
  - The counter is held at 0 in all other states.
  - MEM_LAT = 1 means single-cycle states, with no stall.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 -> RTYPEEX.
    - 000100 -> BEQEX.
    - 001000 -> ADDIEX.
    - 000010 -> JEX.
    - 000011 -> JALEX.
    - anything else -> TRAP.
  - MEMADR -> MEMRD if op = 100011, else MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX, JALEX, TRAP -> FETCH.
- Instruction cycle counts (MEM_LAT = L):
  - lw: 3 + 2L.
  - sw: 2 + 2L.
  - R-type and addi: 3 + L.
  - beq, j, jal, trap: 2 + L.
- Reset asserted mid-instruction returns to FETCH immediately and clears the counter. No write strobe may be issued in the reset cycle beyond the FETCH values above.
- Unreachable encodings (15, and 13 when the feature is off) -> FETCH on the next edge, all outputs 0.

Optional Feature:
- Macro: MC_MAINDEC_BNE_EN.
- Defined: DECODE maps op 000101 (bne) to BNEEX.
  - BNEEX outputs are the same as BEQEX, plus a branch-sense output bne = 1 (extra port `bne`, 1 bit, present only when the macro is defined).
  - BNEEX -> FETCH.
- Undefined: op 000101 goes to TRAP. No bne port exists.

Test Plan:
- Reset and fetch, MEM_LAT = 1: reset high then released, op = 000000.
  - Cycle 0: state 0, irwrite = pcwrite = 1.
  - Cycle 1: state 1.
  - Cycle 2: state 6, alushiftop = 10.
  - Cycle 3: state 7, regdst = regwrite = 1.
  - Cycle 4: state 0.
- lw with MEM_LAT = 3, op = 100011:
  - Expected states: 0, 0, 0, 1, 2, 3, 3, 3, 4, 0.
  - irwrite is high only in cycle 2.
  - memtoreg and regwrite are high only in cycle 8.
- sw with MEM_LAT = 2, op = 101011:
  - Expected states: 0, 0, 1, 2, 5, 5, 0.
  - memwrite is high only in the second MEMWR cycle; regwrite is never asserted.
- jal, op = 000011:
  - Expected states: 0, 1, 12, 0.
  - In state 12: pcsrc = 10, pcwrite = regwrite = link = 1.
- Illegal opcode, op = 111111:
  - Expected states: 0, 1, 14, 0.
  - illegal = 1 for exactly one cycle; no write enables asserted.
  - With MC_MAINDEC_BNE_EN defined, op = 000101 instead yields states 0, 1, 13, 0 with branch = bne = 1.
- Reset mid-instruction: assert reset while in MEMRD (MEM_LAT = 3, counter = 1).
  - State becomes 0 asynchronously and the counter clears.
  - After release, FETCH lasts the full 3 cycles.

Source files
------------

// File: rtl/mc_maindec_if.sv
// Control bus between the multicycle main decoder and the datapath/aludec.
// Optional bne branch-sense line exists only when MC_MAINDEC_BNE_EN is defined.
interface mc_maindec_if #(
    parameter int unsigned OP_W = 6
);
    logic [OP_W-1:0] op;
    logic            memtoreg;
    logic            regdst;
    logic            iord;
    logic [1:0]      pcsrc;
    logic [1:0]      alusrcb;
    logic            alusrca;
    logic            irwrite;
    logic            memwrite;
    logic            pcwrite;
    logic            branch;
    logic            regwrite;
    logic            link;
    logic [1:0]      alushiftop;
    logic            illegal;
    logic [3:0]      state;
`ifdef MC_MAINDEC_BNE_EN
    logic            bne;
`endif

    // Decoder side: consumes the opcode, drives the control lines.
    modport master (
`ifdef MC_MAINDEC_BNE_EN
        output bne,
`endif
        input  op,
        output memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite, memwrite,
        output pcwrite, branch, regwrite, link, alushiftop, illegal, state
    );

    // Datapath side: supplies the opcode, observes the control lines.
    modport slave (
`ifdef MC_MAINDEC_BNE_EN
        input  bne,
`endif
        output op,
        input  memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite, memwrite,
        input  pcwrite, branch, regwrite, link, alushiftop, illegal, state
    );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: Moore FSM with memory states stretched over
// MEM_LAT cycles and a trap state for unsupported opcodes.
// Optional feature macro: MC_MAINDEC_BNE_EN (adds bne dispatch and bus.bne).
module mc_maindec #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned OP_W    = 6
) (
    input logic         clk,
    input logic         reset,
    mc_maindec_if.master bus
);
    typedef enum logic [3:0] {
        s_fetch   = 4'd0,
        s_decode  = 4'd1,
        s_memadr  = 4'd2,
        s_memrd   = 4'd3,
        s_memwb   = 4'd4,
        s_memwr   = 4'd5,
        s_rtypeex = 4'd6,
        s_rtypewb = 4'd7,
        s_beqex   = 4'd8,
        s_addiex  = 4'd9,
        s_addiwb  = 4'd10,
        s_jex     = 4'd11,
        s_jalex   = 4'd12,
        s_bneex   = 4'd13,
        s_trap    = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);
`ifdef MC_MAINDEC_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
`endif
    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last;

    assign last = (cnt_q == CNT_LAST);

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= s_fetch;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; memory states hold until the wait counter reaches its last value.
    always_comb begin
        state_d = s_fetch;
        cnt_d   = 4'd0;
        case (state_q)
            s_fetch: begin
                if (last) state_d = s_decode;
                else begin
                    state_d = s_fetch;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            s_decode: begin
                if (bus.op == OP_LW || bus.op == OP_SW) state_d = s_memadr;
                else if (bus.op == OP_RTYP)             state_d = s_rtypeex;
                else if (bus.op == OP_BEQ)              state_d = s_beqex;
                else if (bus.op == OP_ADDI)             state_d = s_addiex;
                else if (bus.op == OP_J)                state_d = s_jex;
                else if (bus.op == OP_JAL)              state_d = s_jalex;
`ifdef MC_MAINDEC_BNE_EN
                else if (bus.op == OP_BNE)              state_d = s_bneex;
`endif
                else                                    state_d = s_trap;
            end
            s_memadr:  state_d = (bus.op == OP_LW) ? s_memrd : s_memwr;
            s_memrd: begin
                if (last) state_d = s_memwb;
                else begin
                    state_d = s_memrd;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            s_memwr: begin
                if (last) state_d = s_fetch;
                else begin
                    state_d = s_memwr;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            s_rtypeex: state_d = s_rtypewb;
            s_addiex:  state_d = s_addiwb;
            default:   state_d = s_fetch;
        endcase
    end

    // Moore output decode; unlisted outputs stay 0, unreachable codes drive all 0.
    always_comb begin
        bus.memtoreg   = 1'b0;
        bus.regdst     = 1'b0;
        bus.iord       = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.alusrcb    = 2'b00;
        bus.alusrca    = 1'b0;
        bus.irwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.regwrite   = 1'b0;
        bus.link       = 1'b0;
        bus.alushiftop = 2'b00;
        bus.illegal    = 1'b0;
`ifdef MC_MAINDEC_BNE_EN
        bus.bne        = 1'b0;
`endif
        case (state_q)
            s_fetch: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = last;
                bus.pcwrite = last;
            end
            s_decode:  bus.alusrcb = 2'b11;
            s_memadr: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            s_memrd:   bus.iord = 1'b1;
            s_memwb: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            s_memwr: begin
                bus.iord     = 1'b1;
                bus.memwrite = last;
            end
            s_rtypeex: begin
                bus.alusrca    = 1'b1;
                bus.alushiftop = 2'b10;
            end
            s_rtypewb: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            s_beqex: begin
                bus.alusrca    = 1'b1;
                bus.alushiftop = 2'b01;
                bus.pcsrc      = 2'b01;
                bus.branch     = 1'b1;
            end
            s_addiex: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            s_addiwb:  bus.regwrite = 1'b1;
            s_jex: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            s_jalex: begin
                bus.pcsrc    = 2'b10;
                bus.pcwrite  = 1'b1;
                bus.regwrite = 1'b1;
                bus.link     = 1'b1;
            end
`ifdef MC_MAINDEC_BNE_EN
            s_bneex: begin
                bus.alusrca    = 1'b1;
                bus.alushiftop = 2'b01;
                bus.pcsrc      = 2'b01;
                bus.branch     = 1'b1;
                bus.bne        = 1'b1;
            end
`endif
            s_trap:    bus.illegal = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: three instances (MEM_LAT 1, 2, 3) run directed and
// random instruction streams against a per-instruction state-sequence model.
module tb_mc_maindec;
    typedef struct packed {
        logic [3:0] state;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic       alusrca;
        logic       irwrite;
        logic       memwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       link;
        logic [1:0] alushiftop;
        logic       illegal;
        logic       bne;
    } obs_t;

    typedef struct {
        logic [3:0] st;
        bit         last;
    } step_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mc_maindec_if #(.OP_W(6)) if0 ();
    mc_maindec_if #(.OP_W(6)) if1 ();
    mc_maindec_if #(.OP_W(6)) if2 ();

    mc_maindec #(.MEM_LAT(1), .OP_W(6)) u0 (.clk(clk), .reset(rst0), .bus(if0.master));
    mc_maindec #(.MEM_LAT(2), .OP_W(6)) u1 (.clk(clk), .reset(rst1), .bus(if1.master));
    mc_maindec #(.MEM_LAT(3), .OP_W(6)) u2 (.clk(clk), .reset(rst2), .bus(if2.master));

    always #5 clk = ~clk;

`ifdef MC_MAINDEC_BNE_EN
    `define TB_BNE(i) i.bne
`else
    `define TB_BNE(i) 1'b0
`endif
    `define TB_OBS(i) {i.state, i.memtoreg, i.regdst, i.iord, i.pcsrc, i.alusrcb, i.alusrca, \
        i.irwrite, i.memwrite, i.pcwrite, i.branch, i.regwrite, i.link, i.alushiftop, \
        i.illegal, `TB_BNE(i)}

    obs_t obs [3];
    assign obs[0] = `TB_OBS(if0);
    assign obs[1] = `TB_OBS(if1);
    assign obs[2] = `TB_OBS(if2);

    // Control values each state must present, straight from the state table.
    function automatic obs_t exp_out(logic [3:0] st, bit last);
        obs_t e = '0;
        e.state = st;
        case (st)
            4'd0:  begin e.alusrcb = 2'b01; e.irwrite = last; e.pcwrite = last; end
            4'd1:  e.alusrcb = 2'b11;
            4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memwrite = last; end
            4'd6:  begin e.alusrca = 1'b1; e.alushiftop = 2'b10; end
            4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            4'd8:  begin e.alusrca = 1'b1; e.alushiftop = 2'b01; e.pcsrc = 2'b01;
                         e.branch = 1'b1; end
            4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd10: e.regwrite = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
            4'd12: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.regwrite = 1'b1;
                         e.link = 1'b1; end
            4'd13: begin e.alusrca = 1'b1; e.alushiftop = 2'b01; e.pcsrc = 2'b01;
                         e.branch = 1'b1; e.bne = 1'b1; end
            4'd14: e.illegal = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic set_op(input int k, input logic [5:0] v);
        case (k)
            0: if0.op = v;
            1: if1.op = v;
            default: if2.op = v;
        endcase
    endtask

    task automatic set_rst(input int k, input logic v);
        case (k)
            0: rst0 = v;
            1: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    task automatic check(input int k, input string tag, input int idx, input obs_t e);
        tests++;
        assert (obs[k] === e) else begin
            fails++;
            $error("FAIL %s inst=%0d step=%0d observed=%h expected=%h", tag, k, idx, obs[k], e);
        end
    endtask

    // Held for len cycles with only the final cycle flagged as last.
    task automatic push_held(ref step_t q[$], input logic [3:0] st, input int len);
        for (int i = 0; i < len; i++) q.push_back('{st, (i == len - 1)});
    endtask

    // Entered on a negedge in FETCH cycle 0; returns on the next FETCH cycle 0
    // (or after 'limit' steps when limit > 0).
    task automatic run_instr(input int k, input logic [5:0] opc, input int limit);
        step_t q[$];
        int    lat = k + 1;
        push_held(q, 4'd0, lat);
        q.push_back('{4'd1, 1'b0});
        case (opc)
            6'b100011: begin
                q.push_back('{4'd2, 1'b0});
                push_held(q, 4'd3, lat);
                q.push_back('{4'd4, 1'b0});
            end
            6'b101011: begin
                q.push_back('{4'd2, 1'b0});
                push_held(q, 4'd5, lat);
            end
            6'b000000: begin q.push_back('{4'd6, 1'b0}); q.push_back('{4'd7, 1'b0}); end
            6'b001000: begin q.push_back('{4'd9, 1'b0}); q.push_back('{4'd10, 1'b0}); end
            6'b000100: q.push_back('{4'd8, 1'b0});
            6'b000010: q.push_back('{4'd11, 1'b0});
            6'b000011: q.push_back('{4'd12, 1'b0});
`ifdef MC_MAINDEC_BNE_EN
            6'b000101: q.push_back('{4'd13, 1'b0});
`endif
            default:   q.push_back('{4'd14, 1'b0});
        endcase
        set_op(k, opc);
        for (int i = 0; i < q.size(); i++) begin
            if (limit > 0 && i >= limit) break;
            check(k, $sformatf("op%b", opc), i, exp_out(q[i].st, q[i].last));
            @(negedge clk);
        end
    endtask

    // Assert reset on a negedge, check the reset-time outputs, release on the next negedge.
    task automatic do_reset(input int k);
        set_rst(k, 1'b1);
        #1;
        check(k, "reset", 0, exp_out(4'd0, k == 0));
        @(negedge clk);
        set_rst(k, 1'b0);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] pool [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b001000, 6'b000010, 6'b000011, 6'b000101};
        int sel = $urandom_range(0, 8);
        if (sel == 8) return 6'($urandom);
        return pool[sel];
    endfunction

    initial begin
        if0.op = 6'd0;
        if1.op = 6'd0;
        if2.op = 6'd0;
        @(negedge clk);

        // MEM_LAT = 1: R-type, jal, illegal, bne, then a random stream.
        do_reset(0);
        run_instr(0, 6'b000000, 0);
        run_instr(0, 6'b000011, 0);
        run_instr(0, 6'b111111, 0);
        run_instr(0, 6'b000101, 0);
        for (int i = 0; i < 40; i++) run_instr(0, rand_op(), 0);
        set_rst(0, 1'b1);

        // MEM_LAT = 2: sw, then a random stream.
        do_reset(1);
        run_instr(1, 6'b101011, 0);
        for (int i = 0; i < 30; i++) run_instr(1, rand_op(), 0);
        set_rst(1, 1'b1);

        // MEM_LAT = 3: lw, random stream, then reset in MEMRD with counter = 1.
        do_reset(2);
        run_instr(2, 6'b100011, 0);
        for (int i = 0; i < 30; i++) run_instr(2, rand_op(), 0);
        run_instr(2, 6'b100011, 6);
        check(2, "pre_reset_memrd", 6, exp_out(4'd3, 1'b0));
        do_reset(2);
        run_instr(2, 6'b100011, 0);
        run_instr(2, rand_op(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
